// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Desc     : Load-use / branch-operand hazard stall controller with a
//            multi-cycle WAIT state for long load latencies and a memory-busy
//            freeze. The optional HAZ_STALL_CNT_EN macro adds the
//            stall_cnt_clr / stall_cycles bubble counter.
// Revision : 1.0  initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead_EX,
    input  logic             RegWrite_EX,
    input  logic [REG_W-1:0] RegisterDst_EX,
    input  logic [REG_W-1:0] RegisterRs_ID,
    input  logic [REG_W-1:0] RegisterRt_ID,
    input  logic             UsesRs_ID,
    input  logic             UsesRt_ID,
    input  logic             Branch_ID,
    input  logic             mem_busy,
`ifdef HAZ_STALL_CNT_EN
    input  logic             stall_cnt_clr,
    output logic [15:0]      stall_cycles,
`endif
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             nopMux,
    output logic             stall_active
);

    localparam int               CNT_W = $clog2(LOAD_LAT + 2);
    localparam logic [CNT_W-1:0] C_LAT = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             match;
    logic             load_use;
    logic             alu_br;
    logic             stall;
    logic [CNT_W-1:0] n_len;

    always_comb begin
        match    = (RegisterDst_EX != '0) &&
                   ((UsesRs_ID && (RegisterRs_ID == RegisterDst_EX)) ||
                    (UsesRt_ID && (RegisterRt_ID == RegisterDst_EX)));
        load_use = MemRead_EX && match;
        alu_br   = Branch_ID && RegWrite_EX && !MemRead_EX && match;
        // A branch consuming a load result needs one extra cycle to reach ID.
        n_len    = C_LAT + CNT_W'(Branch_ID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        nopMux      = 1'b0;
        if (!rst_n) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            nopMux      = 1'b1;
        end else if (mem_busy) begin
            // Freeze without injecting a bubble; state and count hold.
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            nopMux      = 1'b0;
        end else if (state_q == S_WAIT) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            nopMux      = 1'b1;
            cnt_d       = cnt_q - C_ONE;
            if (cnt_q == C_ONE) begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        end else begin
            stall       = load_use || alu_br;
            PC_write    = !stall;
            IF_ID_write = !stall;
            nopMux      = stall;
            if (load_use && (n_len > C_ONE)) begin
                state_d = S_WAIT;
                cnt_d   = n_len - C_ONE;
            end
        end
    end

    assign stall_active = (state_q == S_WAIT);

`ifdef HAZ_STALL_CNT_EN
    logic [15:0] stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else if (stall_cnt_clr) begin
            stall_cycles_q <= '0;
        end else if (nopMux && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// Bench for hazard_stall_ctrl: four instances (LOAD_LAT 1..4) share one
// directed stimulus stream; expected outputs are queued and then compared.
module tb_hazard_stall_ctrl;

    localparam int REG_W = 5;
    localparam int NI    = 4;
    localparam int L1 = 0, L2 = 1, L3 = 2, L4 = 3;

    // Output codes packed as {PC_write, IF_ID_write, nopMux, stall_active}
    localparam logic [3:0] RUNOK = 4'b1100;
    localparam logic [3:0] STALL = 4'b0010;
    localparam logic [3:0] WAITC = 4'b0011;
    localparam logic [3:0] FRZ   = 4'b0000;
    localparam logic [3:0] FRZW  = 4'b0001;
    localparam logic [3:0] RSTV  = 4'b0010;

    // Flag vectors {MemRead, RegWrite, UsesRs, UsesRt, Branch, mem_busy}
    localparam logic [5:0] F_IDLE  = 6'b000000;
    localparam logic [5:0] F_LD    = 6'b101000;
    localparam logic [5:0] F_LDBR  = 6'b101010;
    localparam logic [5:0] F_LDRT  = 6'b101100;
    localparam logic [5:0] F_LDBSY = 6'b101001;
    localparam logic [5:0] F_BUSY  = 6'b000001;
    localparam logic [5:0] F_ALUBR = 6'b011010;
    localparam logic [5:0] F_ALU   = 6'b011000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             MemRead_EX = 1'b0, RegWrite_EX = 1'b0;
    logic [REG_W-1:0] Dst = '0, Rs = '0, Rt = '0;
    logic             UsesRs = 1'b0, UsesRt = 1'b0, Branch = 1'b0, mem_busy = 1'b0;
    logic [NI-1:0]    pcw, ifw, nop, sact;
`ifdef HAZ_STALL_CNT_EN
    logic             stall_cnt_clr = 1'b0;
    logic [15:0]      sc [NI];
`endif

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            hazard_stall_ctrl #(
                .REG_W   (REG_W),
                .LOAD_LAT(g + 1)
            ) u_dut (
                .clk           (clk),
                .rst_n         (rst_n),
                .MemRead_EX    (MemRead_EX),
                .RegWrite_EX   (RegWrite_EX),
                .RegisterDst_EX(Dst),
                .RegisterRs_ID (Rs),
                .RegisterRt_ID (Rt),
                .UsesRs_ID     (UsesRs),
                .UsesRt_ID     (UsesRt),
                .Branch_ID     (Branch),
                .mem_busy      (mem_busy),
`ifdef HAZ_STALL_CNT_EN
                .stall_cnt_clr (stall_cnt_clr),
                .stall_cycles  (sc[g]),
`endif
                .PC_write      (pcw[g]),
                .IF_ID_write   (ifw[g]),
                .nopMux        (nop[g]),
                .stall_active  (sact[g])
            );
        end
    endgenerate

    typedef struct {
        string      tag;
        int         inst;
        logic [3:0] code;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_out(input string tag, input int inst, input logic [3:0] code);
        exp_t e;
        e.tag  = tag;
        e.inst = inst;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic check_q();
        exp_t       e;
        logic [3:0] obs;
        #1;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = {pcw[e.inst], ifw[e.inst], nop[e.inst], sact[e.inst]};
            checks++;
            assert (obs === e.code) else begin
                errors++;
                $error("FAIL %s (LOAD_LAT=%0d): observed pc/if/nop/sa=%b expected=%b",
                       e.tag, e.inst + 1, obs, e.code);
            end
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic [REG_W-1:0] d,
                         input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt);
        @(negedge clk);
        {MemRead_EX, RegWrite_EX, UsesRs, UsesRt, Branch, mem_busy} = f;
        Dst = d;
        Rs  = rs;
        Rt  = rt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(F_IDLE, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        // Reset values on every instance
        #2;
        for (int i = 0; i < NI; i++) expect_out("reset", i, RSTV);
        check_q();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) expect_out("idle_after_reset", i, RUNOK);
        check_q();

        // Single-cycle load-use with LOAD_LAT=1; LOAD_LAT=2 sits in WAIT
        drive(F_LD, 5'd3, 5'd3, 5'd0);
        expect_out("ld_use_l1", L1, STALL);
        check_q();
        drive(F_IDLE, 5'd0, 5'd0, 5'd0);
        expect_out("bubble_release_l1", L1, RUNOK);
        expect_out("wait_l2", L2, WAITC);
        check_q();
        idle(6);

        // Load feeding a branch with LOAD_LAT=3: four bubbles, last three in WAIT
        drive(F_LDBR, 5'd3, 5'd3, 5'd0);
        expect_out("ldbr_run_l3", L3, STALL);
        check_q();
        for (int i = 0; i < 3; i++) begin
            drive(F_LDBR, 5'd3, 5'd3, 5'd0);
            expect_out("ldbr_wait_l3", L3, WAITC);
            check_q();
        end
        drive(F_IDLE, 5'd0, 5'd0, 5'd0);
        expect_out("ldbr_done_l3", L3, RUNOK);
        check_q();
        idle(6);

        // Register 0 and unused sources never match
        drive(F_LD, 5'd0, 5'd0, 5'd0);
        expect_out("dst_zero", L1, RUNOK);
        check_q();
        drive(F_LD, 5'd5, 5'd2, 5'd5);
        expect_out("rt_unused", L1, RUNOK);
        check_q();
        drive(F_LDRT, 5'd5, 5'd2, 5'd5);
        expect_out("rt_used", L1, STALL);
        check_q();
        idle(6);

        // ALU result needed by a branch in ID: one bubble, no WAIT
        drive(F_ALUBR, 5'd4, 5'd4, 5'd0);
        expect_out("alu_br", L4, STALL);
        check_q();
        drive(F_IDLE, 5'd0, 5'd0, 5'd0);
        expect_out("alu_br_one_cycle", L4, RUNOK);
        check_q();
        drive(F_ALU, 5'd4, 5'd4, 5'd0);
        expect_out("alu_no_branch", L4, RUNOK);
        check_q();
        idle(1);

        // mem_busy in the middle of a LOAD_LAT=2 WAIT
        drive(F_LD, 5'd3, 5'd3, 5'd0);
        expect_out("busy_ld_l2", L2, STALL);
        check_q();
        for (int i = 0; i < 3; i++) begin
            drive(F_BUSY, 5'd0, 5'd0, 5'd0);
            expect_out("busy_freeze_l2", L2, FRZW);
            if (i == 0) expect_out("busy_freeze_run_l1", L1, FRZ);
            check_q();
        end
        drive(F_IDLE, 5'd0, 5'd0, 5'd0);
        expect_out("busy_resume_l2", L2, WAITC);
        check_q();
        drive(F_IDLE, 5'd0, 5'd0, 5'd0);
        expect_out("busy_done_l2", L2, RUNOK);
        check_q();
        idle(6);

        // Hazard masked by mem_busy is taken the first free cycle
        drive(F_LDBSY, 5'd3, 5'd3, 5'd0);
        expect_out("haz_busy", L1, FRZ);
        check_q();
        drive(F_LD, 5'd3, 5'd3, 5'd0);
        expect_out("haz_after_busy", L1, STALL);
        check_q();
        drive(F_IDLE, 5'd0, 5'd0, 5'd0);
        expect_out("haz_after_busy_done", L1, RUNOK);
        check_q();
        idle(6);

        // Asynchronous reset in the second WAIT cycle of LOAD_LAT=4
        drive(F_LD, 5'd3, 5'd3, 5'd0);
        expect_out("rst_ld_l4", L4, STALL);
        check_q();
        drive(F_IDLE, 5'd0, 5'd0, 5'd0);
        expect_out("rst_wait1_l4", L4, WAITC);
        check_q();
        drive(F_IDLE, 5'd0, 5'd0, 5'd0);
        expect_out("rst_wait2_l4", L4, WAITC);
        check_q();
        rst_n = 1'b0;
        expect_out("rst_async_l4", L4, RSTV);
        check_q();
        drive(F_IDLE, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b1;
        expect_out("post_rst_l4", L4, RUNOK);
        expect_out("post_rst_l3", L3, RUNOK);
        check_q();

`ifdef HAZ_STALL_CNT_EN
        // Counter saturation and clear on the LOAD_LAT=1 instance
        @(negedge clk);
        stall_cnt_clr = 1'b1;
        @(negedge clk);
        stall_cnt_clr = 1'b0;
        for (int i = 0; i < 70000; i++) drive(F_LD, 5'd3, 5'd3, 5'd0);
        #1;
        checks++;
        assert (sc[L1] === 16'hFFFF) else begin
            errors++;
            $error("FAIL cnt_saturate: observed=%h expected=%h", sc[L1], 16'hFFFF);
        end
        @(negedge clk);
        stall_cnt_clr = 1'b1;
        @(negedge clk);
        stall_cnt_clr = 1'b0;
        #1;
        checks++;
        assert (sc[L1] === 16'h0000) else begin
            errors++;
            $error("FAIL cnt_clear: observed=%h expected=%h", sc[L1], 16'h0000);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
